vga_pattern_gen: RTL and testbench

// - Sits directly downstream of the VGA sync generator: consumes its HSync/VSync/Colour_On, emits 3-bit RGB + re-timed syncs to the DAC pins.
// - Recovers pixel column/row from Colour_On/VSync edges; renders one of four test patterns, selectable by a button pulse.
// - Pattern change is frame-synchronous (no tearing); bouncing box moves once per frame.

---
 rtl/vga_pkg.sv | 28 ++
 rtl/vga_box_mover.sv | 55 +++++
 rtl/vga_pattern_gen.sv | 127 ++++++++++++
 tb/tb_vga_pattern_gen.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, colours and pattern encoding for the VGA test-pattern generator.
package vga_pkg;

  localparam int ACTIVE_WIDTH  = 640;
  localparam int ACTIVE_HEIGHT = 480;
  localparam int BAR_WIDTH     = 80;
  localparam int CHECK_SHIFT   = 5;
  localparam int BOX_SIZE      = 32;
  localparam int BOX_STEP      = 2;

  // Pixel coordinate width, and one extra bit for signed box-bound arithmetic
  localparam int CNT_W = 10;
  localparam int POS_W = CNT_W + 1;

  // Colours packed as {R[2:0], G[2:0], B[2:0]}
  localparam logic [8:0] BLACK = 9'b000_000_000;
  localparam logic [8:0] WHITE = 9'b111_111_111;
  localparam logic [8:0] BLUE  = 9'b000_000_111;
  localparam logic [8:0] GREEN = 9'b000_111_000;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_CHECK = 2'd1,
    PAT_BOX   = 2'd2,
    PAT_GRID  = 2'd3
  } pattern_t;

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position: moves BOX_STEP pixels on each axis per step strobe,
// clamping to the visible area and reversing direction at either edge.
module vga_box_mover
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  output logic [CNT_W-1:0] bx,
  output logic [CNT_W-1:0] by
);

  localparam logic signed [POS_W-1:0] X_MAX = POS_W'(ACTIVE_WIDTH - BOX_SIZE);
  localparam logic signed [POS_W-1:0] Y_MAX = POS_W'(ACTIVE_HEIGHT - BOX_SIZE);
  localparam logic signed [POS_W-1:0] STEP  = POS_W'(BOX_STEP);

  logic                    dx_neg;
  logic                    dy_neg;
  logic signed [POS_W-1:0] nx;
  logic signed [POS_W-1:0] ny;
  logic        [POS_W-1:0] x_upd;
  logic        [POS_W-1:0] y_upd;

  // Returns {flip, position}: clamp to [0, lim] and request a direction flip when clamped
  function automatic logic [POS_W-1:0] bounce(input logic signed [POS_W-1:0] n,
                                              input logic signed [POS_W-1:0] lim);
    if (n > lim)
      return {1'b1, lim[CNT_W-1:0]};
    else if (n < $signed(POS_W'(0)))
      return {1'b1, {CNT_W{1'b0}}};
    else
      return {1'b0, n[CNT_W-1:0]};
  endfunction

  assign nx    = dx_neg ? $signed({1'b0, bx}) - STEP : $signed({1'b0, bx}) + STEP;
  assign ny    = dy_neg ? $signed({1'b0, by}) - STEP : $signed({1'b0, by}) + STEP;
  assign x_upd = bounce(nx, X_MAX);
  assign y_upd = bounce(ny, Y_MAX);

  // Advance both axes independently on each frame-start strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx     <= '0;
      by     <= '0;
      dx_neg <= 1'b0;
      dy_neg <= 1'b0;
    end else if (step) begin
      bx     <= x_upd[CNT_W-1:0];
      by     <= y_upd[CNT_W-1:0];
      dx_neg <= dx_neg ^ x_upd[CNT_W];
      dy_neg <= dy_neg ^ y_upd[CNT_W];
    end
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: recovers pixel position from the upstream sync
// generator's strobes and renders one of four patterns, two cycles behind the
// inputs with the syncs re-timed to match.
module vga_pattern_gen
  import vga_pkg::*;
(
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_HSync,
  input  logic       i_VSync,
  input  logic       i_Colour_On,
  input  logic       i_Next,
  output logic       o_HSync,
  output logic       o_VSync,
  output logic [2:0] o_Red,
  output logic [2:0] o_Grn,
  output logic [2:0] o_Blu
);

  logic             hsync_p1;
  logic             vsync_p1;
  logic             vld_p1;
  logic [CNT_W-1:0] col_p1;
  logic [CNT_W-1:0] row_p1;
  pattern_t         active_pat;
  pattern_t         pending_pat;
  logic [CNT_W-1:0] bx;
  logic [CNT_W-1:0] by;
  logic             frame_start;
  logic             line_start;
  logic             line_end;
  logic [2:0]       bar_idx;
  logic             in_box;
  logic             visible;
  logic [8:0]       rgb;

  // Counter increment that sticks at all-ones instead of wrapping
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Edges are taken between the live inputs and their stage-1 copies
  assign frame_start = vsync_p1 & ~i_VSync;
  assign line_start  = i_Colour_On & ~vld_p1;
  assign line_end    = ~i_Colour_On & vld_p1;

  // ---- Stage 1: input capture, edge detect, column/row recovery ----
  // Register inputs and track the pixel position they describe
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      col_p1   <= '0;
      row_p1   <= '0;
    end else begin
      hsync_p1 <= i_HSync;
      vsync_p1 <= i_VSync;
      vld_p1   <= i_Colour_On;
      if (line_start)
        col_p1 <= '0;
      else if (i_Colour_On)
        col_p1 <= sat_inc(col_p1);
      if (frame_start)
        row_p1 <= '0;
      else if (line_end)
        row_p1 <= sat_inc(row_p1);
    end
  end

  // Button presses queue up; the displayed pattern only changes at frame start
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      pending_pat <= PAT_BARS;
      active_pat  <= PAT_BARS;
    end else begin
      if (i_Next)
        pending_pat <= pattern_t'(pending_pat + 2'd1);
      if (frame_start)
        active_pat <= pending_pat;
    end
  end

  vga_box_mover u_box (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .step  (frame_start),
    .bx    (bx),
    .by    (by)
  );

  // ---- Stage 2: pattern mux and output registers ----
  assign bar_idx = 3'(col_p1 / CNT_W'(BAR_WIDTH));
  assign in_box  = (col_p1 >= bx) && ({1'b0, col_p1} < ({1'b0, bx} + POS_W'(BOX_SIZE))) &&
                   (row_p1 >= by) && ({1'b0, row_p1} < ({1'b0, by} + POS_W'(BOX_SIZE)));
  assign visible = vld_p1 && (col_p1 < CNT_W'(ACTIVE_WIDTH)) && (row_p1 < CNT_W'(ACTIVE_HEIGHT));

  // Pick the colour for the current pixel; blank outside the active area
  always_comb begin
    rgb = BLACK;
    case (active_pat)
      PAT_BARS:  rgb = {{3{bar_idx[2]}}, {3{bar_idx[1]}}, {3{bar_idx[0]}}};
      PAT_CHECK: rgb = (col_p1[CHECK_SHIFT] ^ row_p1[CHECK_SHIFT]) ? WHITE : BLACK;
      PAT_BOX:   rgb = in_box ? WHITE : BLUE;
      PAT_GRID:  rgb = ((col_p1[5:0] == 6'd0) || (row_p1[5:0] == 6'd0)) ? GREEN : BLACK;
      default:   rgb = BLACK;
    endcase
    if (!visible)
      rgb = BLACK;
  end

  // Output registers keep syncs and colour on the same cycle
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      o_HSync <= 1'b0;
      o_VSync <= 1'b0;
      o_Red   <= 3'd0;
      o_Grn   <= 3'd0;
      o_Blu   <= 3'd0;
    end else begin
      o_HSync               <= hsync_p1;
      o_VSync               <= vsync_p1;
      {o_Red, o_Grn, o_Blu} <= rgb;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: the stimulus pushes expected
// {HSync, VSync, RGB} with the cycle it must appear; a monitor pops and compares.
`timescale 1ns/1ps
module tb_vga_pattern_gen;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       hs    = 1'b1;
  logic       vs    = 1'b1;
  logic       co    = 1'b0;
  logic       nxt   = 1'b0;
  logic       hs_o, vs_o;
  logic [2:0] red, grn, blu;

  vga_pattern_gen dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_n),
    .i_HSync     (hs),
    .i_VSync     (vs),
    .i_Colour_On (co),
    .i_Next      (nxt),
    .o_HSync     (hs_o),
    .o_VSync     (vs_o),
    .o_Red       (red),
    .o_Grn       (grn),
    .o_Blu       (blu)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [10:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   applied     = 0;
  int   miscompares = 0;

  // Monitor: compare every expectation that is due on this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      mon_e = sb.pop_front();
      applied++;
      if (mon_e.at != cyc || {hs_o, vs_o, red, grn, blu} !== mon_e.val) begin
        miscompares++;
        $display("FAIL %s @cyc %0d (due %0d): got hs=%b vs=%b rgb=%o, required hs=%b vs=%b rgb=%o",
                 mon_e.name, cyc, mon_e.at, hs_o, vs_o, {red, grn, blu},
                 mon_e.val[10], mon_e.val[9], mon_e.val[8:0]);
      end
    end
  end

  initial begin
    #600us;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_raw(input string name, input int at, input logic [10:0] val);
    exp_t e;
    e.at = at; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  // Expectation for the inputs just driven: appears two cycles later
  task automatic push(input string name, input logic [8:0] rgb);
    push_raw(name, cyc + 2, {hs, vs, rgb});
  endtask

  task automatic drive(input logic h, input logic v, input logic c, input logic n);
    @(posedge clk);
    #1;
    hs = h; vs = v; co = c; nxt = n;
  endtask

  int          ck_col[$];
  logic [8:0]  ck_rgb[$];

  task automatic add_ck(input int c, input logic [8:0] r);
    ck_col.push_back(c);
    ck_rgb.push_back(r);
  endtask

  // One visible line of len pixels followed by a short blanking with an HSync pulse
  task automatic run_line(input int len, input int next_at, input string tag);
    for (int c = 0; c < len; c++) begin
      drive(1'b1, 1'b1, 1'b1, (c == next_at));
      for (int k = 0; k < ck_col.size(); k++)
        if (ck_col[k] == c) push($sformatf("%s col%0d", tag, c), ck_rgb[k]);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0); push({tag, " blank"}, 9'o000);
    drive(1'b0, 1'b1, 1'b0, 1'b0); push({tag, " hsync"}, 9'o000);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    ck_col.delete();
    ck_rgb.delete();
  endtask

  task automatic short_lines(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Expected box motion, worked out from the bounce rule
  int frames = 0;
  int bx_m = 0, by_m = 0, dx_m = 1, dy_m = 1;

  task automatic box_reset();
    frames = 0; bx_m = 0; by_m = 0; dx_m = 1; dy_m = 1;
  endtask

  task automatic box_step();
    int n;
    n = bx_m + 2 * dx_m;
    if (n > 608)    begin bx_m = 608; dx_m = -dx_m; end
    else if (n < 0) begin bx_m = 0;   dx_m = -dx_m; end
    else bx_m = n;
    n = by_m + 2 * dy_m;
    if (n > 448)    begin by_m = 448; dy_m = -dy_m; end
    else if (n < 0) begin by_m = 0;   dy_m = -dy_m; end
    else by_m = n;
  endtask

  task automatic frame(input logic n);
    drive(1'b1, 1'b0, 1'b0, n);
    push("vsync low", 9'o000);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    frames++;
    box_step();
  endtask

  // Walk down to the box's top row (starting at row 0) and probe its edges
  task automatic check_box(input string tag);
    int len;
    if (by_m > 0) begin
      short_lines(by_m - 1);
      add_ck(bx_m, 9'o007);
      run_line(bx_m + 1, -1, $sformatf("%s above y%0d", tag, by_m - 1));
    end
    if (bx_m > 0) add_ck(bx_m - 1, 9'o007);
    add_ck(bx_m, 9'o777);
    add_ck(bx_m + 31, 9'o777);
    if (bx_m + 32 < 640) add_ck(bx_m + 32, 9'o007);
    len = (bx_m + 33 > 640) ? 640 : bx_m + 33;
    run_line(len, -1, $sformatf("%s x%0d y%0d", tag, bx_m, by_m));
  endtask

  initial begin
    // Reset: everything zero even with syncs high on the inputs
    @(posedge clk); #1;
    push_raw("reset", cyc, 11'd0);
    push_raw("reset", cyc + 1, 11'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 1'b0);

    // Pattern 0 colour bars, rows 0..2
    add_ck(0, 9'o000);   add_ck(79, 9'o000);  add_ck(80, 9'o007);  add_ck(160, 9'o070);
    add_ck(240, 9'o077); add_ck(320, 9'o700); add_ck(559, 9'o770); add_ck(560, 9'o777);
    add_ck(639, 9'o777);
    run_line(640, -1, "bars r0");
    add_ck(80, 9'o007); add_ck(639, 9'o777);
    run_line(640, -1, "bars r1");
    add_ck(400, 9'o707);
    run_line(640, -1, "bars r2");

    // Past the right edge must blank even where bar index would wrap
    add_ck(639, 9'o777); add_ck(640, 9'o000); add_ck(720, 9'o000);
    run_line(730, -1, "bars wide");

    // One press mid-frame: no change until the next frame
    add_ck(80, 9'o007); add_ck(200, 9'o070);
    run_line(640, 100, "next midframe");
    add_ck(80, 9'o007);
    run_line(640, -1, "next same frame");
    frame(1'b0);
    add_ck(0, 9'o000); add_ck(31, 9'o000); add_ck(32, 9'o777); add_ck(63, 9'o777); add_ck(64, 9'o000);
    run_line(100, -1, "checker r0");

    // Press on the frame-start cycle: still checker this frame
    frame(1'b1);
    add_ck(0, 9'o000); add_ck(32, 9'o777);
    run_line(100, -1, "checker held");

    // Pending now box
    frame(1'b0);
    check_box("box f3");

    // Five presses in one frame: box(2) + 5 = grid(3)
    pulses(5);
    frame(1'b0);
    add_ck(0, 9'o070); add_ck(1, 9'o070); add_ck(64, 9'o070); add_ck(640, 9'o000);
    run_line(650, -1, "grid r0");
    add_ck(0, 9'o070); add_ck(1, 9'o000); add_ck(63, 9'o000); add_ck(64, 9'o070);
    run_line(100, -1, "grid r1");

    // Back to box and let it travel
    pulses(3);
    frame(1'b0);
    while (frames < 306) frame(1'b0);
    check_box("box f306");
    while (frames < 400) frame(1'b0);
    check_box("box f400");

    // Reset in the middle of a visible line
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    push_raw("midline reset", cyc, 11'd0);
    @(posedge clk); #1;
    push_raw("midline reset held", cyc, 11'd0);
    co = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    box_reset();
    add_ck(0, 9'o000); add_ck(80, 9'o007); add_ck(85, 9'o007);
    run_line(100, -1, "after reset bars");
    pulses(2);
    frame(1'b0);
    check_box("box after reset");

    repeat (4) drive(1'b1, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    if (sb.size() != 0) begin
      miscompares += sb.size();
      $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
